// File: rtl/sound_tone_gen.sv
// sound_tone_gen
// Square-wave tone synthesiser for the game sound path. A free-running
// divider produces one sample tick every SAMPLE_DIV clocks. On each tick a
// 16-bit DDS phase accumulator advances and an attack/sustain/release
// envelope is stepped. The output sample is +env or -env, chosen by the
// phase MSB.
//
// Ports:
//   clk          in   system clock (50 MHz)
//   resetN       in   asynchronous active-low reset
//   play         in   level request; the tone sounds while it is high
//   tone [3:0]   in   note index, chromatic C4..D#5
//   audio_out    out  signed 16-bit PCM sample, registered
//   sample_valid out  one-cycle strobe marking a new audio_out
//   busy         out  high while the voice is not idle, registered
module sound_tone_gen #(
    parameter int SAMPLE_DIV   = 1024,
    parameter int AMP_MAX      = 12000,
    parameter int ATTACK_STEP  = 500,
    parameter int RELEASE_STEP = 250
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        play,
    input  logic [3:0]  tone,
    output logic [15:0] audio_out,
    output logic        sample_valid,
    output logic        busy
);

    localparam int CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(SAMPLE_DIV - 1);
    localparam logic [14:0]   AMP_L     = 15'(AMP_MAX);
    localparam logic [14:0]   ATK_L     = 15'(ATTACK_STEP);
    localparam logic [14:0]   REL_L     = 15'(RELEASE_STEP);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ATTACK  = 2'd1,
        ST_SUSTAIN = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    // Phase increments for C4..D#5 at a 48.828 kHz sample rate.
    function automatic logic [15:0] inc_lut(input logic [3:0] idx);
        logic [15:0] val;
        case (idx)
            4'd0:    val = 16'd351;
            4'd1:    val = 16'd372;
            4'd2:    val = 16'd394;
            4'd3:    val = 16'd418;
            4'd4:    val = 16'd442;
            4'd5:    val = 16'd469;
            4'd6:    val = 16'd497;
            4'd7:    val = 16'd526;
            4'd8:    val = 16'd557;
            4'd9:    val = 16'd591;
            4'd10:   val = 16'd626;
            4'd11:   val = 16'd663;
            4'd12:   val = 16'd702;
            4'd13:   val = 16'd744;
            4'd14:   val = 16'd788;
            4'd15:   val = 16'd835;
            default: val = 16'd351;
        endcase
        return val;
    endfunction

    logic [CW-1:0] tick_cnt_q, tick_cnt_d;
    logic [15:0]   phase_q, phase_d;
    logic [14:0]   env_q, env_d;
    logic [15:0]   inc_q, inc_d;
    state_t        state_q, state_d;
    logic [15:0]   audio_out_q, audio_out_d;
    logic          sample_valid_q, sample_valid_d;
    logic          busy_q, busy_d;

    logic          tick_s;
    logic [15:0]   attack_sum_s;
    logic [14:0]   attack_env_s;
    logic [14:0]   release_env_s;
    logic [16:0]   phase_sum_s;
    logic          go_attack_s;
    logic          go_release_s;

    // Next-state, envelope, phase and output computation.
    always_comb begin
        tick_s        = (tick_cnt_q == TICK_LAST);
        attack_sum_s  = {1'b0, env_q} + {1'b0, ATK_L};
        attack_env_s  = (attack_sum_s >= {1'b0, AMP_L}) ? AMP_L : attack_sum_s[14:0];
        release_env_s = (env_q > REL_L) ? (env_q - REL_L) : 15'd0;
        phase_sum_s   = {1'b0, phase_q} + {1'b0, inc_q};

        tick_cnt_d     = tick_s ? {CW{1'b0}} : (tick_cnt_q + CW'(1));
        state_d        = state_q;
        env_d          = env_q;
        phase_d        = phase_q;
        inc_d          = inc_q;
        audio_out_d    = audio_out_q;
        sample_valid_d = 1'b0;
        busy_d         = busy_q;
        go_attack_s    = 1'b0;
        go_release_s   = 1'b0;

        if (tick_s) begin
            // A transition applies the envelope step of the state entered,
            // so the first sample of an attack or release already moves.
            case (state_q)
                ST_IDLE: begin
                    go_attack_s  = play;
                    go_release_s = 1'b0;
                end
                ST_ATTACK: begin
                    go_attack_s  = play;
                    go_release_s = ~play;
                end
                ST_SUSTAIN: begin
                    go_attack_s  = 1'b0;
                    go_release_s = ~play;
                end
                ST_RELEASE: begin
                    go_attack_s  = play;
                    go_release_s = ~play;
                end
                default: begin
                    go_attack_s  = 1'b0;
                    go_release_s = 1'b0;
                end
            endcase

            if (go_attack_s) begin
                env_d   = attack_env_s;
                state_d = (attack_env_s == AMP_L) ? ST_SUSTAIN : ST_ATTACK;
            end else if (go_release_s) begin
                env_d   = release_env_s;
                state_d = (release_env_s == 15'd0) ? ST_IDLE : ST_RELEASE;
            end else begin
                env_d   = env_q;
                state_d = state_q;
            end

            // The increment only changes at a note start or a period
            // boundary, which keeps tone changes glitch-free.
            if (state_q == ST_IDLE) begin
                phase_d = 16'd0;
                inc_d   = play ? inc_lut(tone) : inc_q;
            end else begin
                phase_d = (state_d == ST_IDLE) ? 16'd0 : phase_sum_s[15:0];
                inc_d   = phase_sum_s[16] ? inc_lut(tone) : inc_q;
            end

            audio_out_d    = phase_d[15] ? (16'd0 - {1'b0, env_d}) : {1'b0, env_d};
            sample_valid_d = 1'b1;
            busy_d         = (state_d != ST_IDLE);
        end else begin
            sample_valid_d = 1'b0;
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            tick_cnt_q     <= {CW{1'b0}};
            phase_q        <= 16'd0;
            env_q          <= 15'd0;
            inc_q          <= 16'd0;
            state_q        <= ST_IDLE;
            audio_out_q    <= 16'd0;
            sample_valid_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            tick_cnt_q     <= tick_cnt_d;
            phase_q        <= phase_d;
            env_q          <= env_d;
            inc_q          <= inc_d;
            state_q        <= state_d;
            audio_out_q    <= audio_out_d;
            sample_valid_q <= sample_valid_d;
            busy_q         <= busy_d;
        end
    end

    assign audio_out    = audio_out_q;
    assign sample_valid = sample_valid_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_sound_tone_gen.sv
// Testbench for sound_tone_gen: directed note sequences with a reference
// model feeding an expected-sample queue that is drained on each strobe.
module tb_sound_tone_gen;

    localparam int DIV = 32;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        play = 1'b0;
    logic [3:0]  tone = 4'd0;
    logic [15:0] audio_out;
    logic        sample_valid;
    logic        busy;

    sound_tone_gen #(
        .SAMPLE_DIV  (DIV),
        .AMP_MAX     (12000),
        .ATTACK_STEP (500),
        .RELEASE_STEP(250)
    ) dut (
        .clk         (clk),
        .resetN      (resetN),
        .play        (play),
        .tone        (tone),
        .audio_out   (audio_out),
        .sample_valid(sample_valid),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int audio;
        int busy;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   last_audio = 0;
    int   max_mag = 0;

    int tbl[16] = '{351, 372, 394, 418, 442, 469, 497, 526,
                    557, 591, 626, 663, 702, 744, 788, 835};

    // Reference voice: 0 idle, 1 attack, 2 sustain, 3 release.
    int m_st = 0;
    int m_env = 0;
    int m_phase = 0;
    int m_inc = 0;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_env = 0; m_phase = 0; m_inc = 0;
    endtask

    task automatic model_tick(input logic p, input logic [3:0] t, output exp_t e);
        int nst, nenv, nph;
        nst = m_st;
        if (m_st == 0) begin
            if (p) begin
                nst = 1;
                m_inc = tbl[t];
            end
        end else if (!p) begin
            nst = 3;
        end else if (m_st == 3) begin
            nst = 1;
        end
        nenv = m_env;
        if (nst == 1) begin
            nenv = m_env + 500;
            if (nenv >= 12000) begin nenv = 12000; nst = 2; end
        end else if (nst == 3) begin
            nenv = m_env - 250;
            if (nenv <= 0) begin nenv = 0; nst = 0; end
        end else if (nst == 0) begin
            nenv = 0;
        end
        nph = m_phase;
        if (m_st != 0) begin
            nph = m_phase + m_inc;
            if (nph >= 65536) begin
                nph = nph - 65536;
                m_inc = tbl[t];
            end
        end
        if (nst == 0) nph = 0;
        e.audio = (nph >= 32768) ? -nenv : nenv;
        e.busy  = (nst != 0) ? 1 : 0;
        m_st = nst; m_env = nenv; m_phase = nph;
    endtask

    // Drive one tick's inputs, queue the expected sample, wait for the strobe
    // and compare.
    task automatic step(input logic p, input logic [3:0] t);
        exp_t e;
        int   n;
        play = p;
        tone = t;
        model_tick(p, t, e);
        sb.push_back(e);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (sample_valid !== 1'b1 && n < 2 * DIV);
        chk("sample_gap", n, DIV);
        e = sb.pop_front();
        chk("audio", $signed(audio_out), e.audio);
        chk("busy", {31'd0, busy}, e.busy);
        last_audio = $signed(audio_out);
        if (iabs(last_audio) > max_mag) max_mag = iabs(last_audio);
    endtask

    task automatic steps(input int count, input logic p, input logic [3:0] t);
        for (int i = 0; i < count; i++) step(p, t);
    endtask

    initial begin
        // Reset values while held in reset.
        repeat (3) @(negedge clk);
        chk("rst_audio", $signed(audio_out), 0);
        chk("rst_valid", {31'd0, sample_valid}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        model_reset();
        resetN = 1'b1;

        // Idle ticks: silent, not busy, strobe every DIV cycles.
        steps(5, 1'b0, 4'd0);

        // Note on, tone 3: ramp to full amplitude in 24 samples.
        steps(24, 1'b1, 4'd3);
        chk("ramp_peak", iabs(last_audio), 12000);
        steps(100, 1'b1, 4'd3);

        // Tone change in sustain takes effect at the next phase wrap.
        steps(60, 1'b1, 4'd15);
        chk("amp_limit", max_mag, 12000);

        // Note off: 48 release samples to silence.
        steps(47, 1'b0, 4'd15);
        chk("release_47", iabs(last_audio), 250);
        step(1'b0, 4'd15);
        chk("release_end", $signed(audio_out), 0);
        chk("release_busy", {31'd0, busy}, 0);
        steps(2, 1'b0, 4'd0);

        // Re-trigger during release at 6000.
        steps(24, 1'b1, 4'd7);
        steps(24, 1'b0, 4'd7);
        chk("release_6000", iabs(last_audio), 6000);
        step(1'b1, 4'd7);
        chk("reattack_mag", iabs(last_audio), 6500);
        steps(3, 1'b1, 4'd7);

        // Reset during attack: outputs clear at once.
        #2;
        resetN = 1'b0;
        #1;
        chk("midrst_audio", $signed(audio_out), 0);
        chk("midrst_valid", {31'd0, sample_valid}, 0);
        chk("midrst_busy", {31'd0, busy}, 0);
        sb.delete();
        model_reset();
        @(negedge clk);
        resetN = 1'b1;
        steps(5, 1'b0, 4'd5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
